// File: rtl/master_line_driver.sv
// master_line_driver
//   Master-side serial signalling generator. Turns parallel master commands
//   (bus request + slave id, ack/nak, end of transfer, split suspend/resume)
//   into the fixed serial bit codes decoded by the master port on port_in.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   req_valid    bus request, accepted while req_ready is high
//   req_ready    high only in IDLE
//   req_id       target slave id, captured on an accepted request
//   grant        bus granted to this master (level, only looked at in WAITG)
//   slave_ok     sampled with grant: 1 = ACK code, 0 = NAK code
//   xfer_end     pulse: finish the current transfer
//   suspend      pulse: split, release the bus but keep the session
//   resume       pulse: resume a suspended session
//   ser_out      registered serial line (idles at 0)
//   busy         high whenever not in IDLE
//   timeout_err  one-cycle pulse when the grant wait expires
//   suspended    high in SUSP
module master_line_driver #(
  parameter int NO_SLAVES     = 3,
  parameter int GRANT_TIMEOUT = 64,
  localparam int N            = $clog2(NO_SLAVES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_id,
  input  logic         grant,
  input  logic         slave_ok,
  input  logic         xfer_end,
  input  logic         suspend,
  input  logic         resume,
  output logic         ser_out,
  output logic         busy,
  output logic         timeout_err,
  output logic         suspended
);

  localparam int CW = ($clog2(N) > 2) ? $clog2(N) : 2;
  localparam int WW = $clog2(GRANT_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, REQ, ID, WAITG, ACKS, HOLD, ENDS, SUSP, RESS
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   bit_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [N-1:0]    id_sh;      // captured id, shifted left as bits go out
  logic            ok_q;       // slave_ok sampled with grant
  logic            ser_next;
  logic            to_next;

  // Every output bit is computed here for the current state and registered
  // below, so the line lags the state register by exactly one cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    ser_next   = 1'b0;
    to_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) state_next = REQ;
      end
      REQ: begin
        ser_next = 1'b1;
        if (bit_cnt == CW'(2)) state_next = ID;
      end
      ID: begin
        ser_next = id_sh[N-1];
        if (bit_cnt == CW'(N - 1)) state_next = WAITG;
      end
      WAITG: begin
        // Grant on the final wait cycle still wins over the timeout.
        if (grant) begin
          state_next = ACKS;
        end else if (wait_cnt == WW'(GRANT_TIMEOUT - 1)) begin
          to_next    = 1'b1;
          state_next = IDLE;
        end
      end
      ACKS: begin
        if (ok_q) begin
          ser_next = (bit_cnt != CW'(1));            // 1,0,1
          if (bit_cnt == CW'(2)) state_next = HOLD;
        end else begin
          ser_next = (bit_cnt != CW'(2));            // 1,1,0
          if (bit_cnt == CW'(2)) state_next = IDLE;
        end
      end
      HOLD: begin
        // Line parked at 1 so the 0,1 end code cannot appear mid-transfer.
        ser_next = 1'b1;
        if (xfer_end)     state_next = ENDS;
        else if (suspend) state_next = SUSP;
      end
      ENDS: begin
        ser_next = (bit_cnt == CW'(1));              // 0,1
        if (bit_cnt == CW'(1)) state_next = IDLE;
      end
      SUSP: begin
        if (xfer_end)    state_next = IDLE;
        else if (resume) state_next = RESS;
      end
      RESS: begin
        ser_next = (bit_cnt == CW'(1));              // 0,1,0
        if (bit_cnt == CW'(2)) state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register, the captured id included, is reset so an abort in
    // mid-frame cannot leak stale bits into the next frame.
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      id_sh       <= '0;
      ok_q        <= 1'b0;
      ser_out     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      ser_out     <= ser_next;
      timeout_err <= to_next;
      bit_cnt     <= (state_next != state) ? '0 : bit_cnt + CW'(1);
      wait_cnt    <= (state == WAITG && state_next == WAITG) ? wait_cnt + WW'(1) : '0;
      if (state == IDLE && req_valid) id_sh <= req_id;
      else if (state == ID)           id_sh <= id_sh << 1;
      if (state == WAITG && grant)    ok_q  <= slave_ok;
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign suspended = (state == SUSP);

endmodule

// File: tb/tb_master_line_driver.sv
// Directed bench for master_line_driver (NO_SLAVES=3, GRANT_TIMEOUT=8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_master_line_driver;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req_id = '0;
  logic         grant = 1'b0;
  logic         slave_ok = 1'b0;
  logic         xfer_end = 1'b0;
  logic         suspend = 1'b0;
  logic         resume = 1'b0;
  logic         ser_out;
  logic         busy;
  logic         timeout_err;
  logic         suspended;

  int tests = 0;
  int fails = 0;

  master_line_driver #(.NO_SLAVES(3), .GRANT_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .grant(grant), .slave_ok(slave_ok),
    .xfer_end(xfer_end), .suspend(suspend), .resume(resume),
    .ser_out(ser_out), .busy(busy), .timeout_err(timeout_err),
    .suspended(suspended)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; the state after acceptance must not be ready.
  task automatic send_request(input logic [N-1:0] id);
    req_valid = 1'b1;
    req_id    = id;
    step();
    req_valid = 1'b0;
    check("req_ready_after_accept", req_ready, 1'b0);
  endtask

  // Step n cycles comparing ser_out to bits[n-1] .. bits[0]; grant is raised
  // for the single edge following the check at cycle grant_at (0 = never).
  task automatic serial_check(input string tag, input logic [31:0] bits,
                              input int n, input int grant_at);
    for (int i = 1; i <= n; i++) begin
      step();
      check($sformatf("%s_bit%0d", tag, i), ser_out, bits[n-i]);
      grant = (i == grant_at);
    end
    grant = 1'b0;
  endtask

  initial begin
    // ---- reset values ----
    #2 rst = 1'b1;
    #1;
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_suspended", suspended, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---- pulses ignored in IDLE ----
    xfer_end = 1'b1; suspend = 1'b1; resume = 1'b1;
    step();
    xfer_end = 1'b0; suspend = 1'b0; resume = 1'b0;
    check("idle_pulses_busy", busy, 1'b0);
    step();
    check("idle_pulses_ser", ser_out, 1'b0);

    // ---- ACK frame: id 10, grant in 5th WAITG cycle ----
    slave_ok = 1'b1;
    send_request(2'b10);
    serial_check("ack", 32'hF02F, 16, 9);   // 1111 000000 101 111
    check("ack_hold_busy", busy, 1'b1);

    // ---- suspend, 4-cycle gap, resume, then end ----
    suspend = 1'b1;
    step();
    suspend = 1'b0;
    check("susp_enter", suspended, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("susp_gap_ser%0d", i), ser_out, 1'b0);
      check($sformatf("susp_gap_flag%0d", i), suspended, 1'b1);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_flag", suspended, 1'b0);
    serial_check("ress", 32'b01011, 5, 0);  // 0,1,0 then HOLD 1s
    xfer_end = 1'b1;
    step();
    xfer_end = 1'b0;
    check("ends_busy_in", busy, 1'b1);
    serial_check("ends", 32'b01, 2, 0);
    check("ends_busy_out", busy, 1'b0);
    step();
    check("ends_line_idle", ser_out, 1'b0);

    // ---- NAK frame ----
    slave_ok = 1'b0;
    send_request(2'b10);
    serial_check("nak", 32'b111100000011, 12, 9);
    check("nak_not_ready", req_ready, 1'b0);
    step();
    check("nak_last_bit", ser_out, 1'b0);
    check("nak_ready", req_ready, 1'b1);

    // ---- grant timeout: WAITG entered 5 edges after accept ----
    send_request(2'b00);
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("to_ser%0d", i), ser_out, (i <= 3));
      check($sformatf("to_pulse%0d", i), timeout_err, (i == 13));
      check($sformatf("to_busy%0d", i), busy, (i < 13));
    end

    // ---- xfer_end and suspend together in HOLD ----
    slave_ok = 1'b1;
    send_request(2'b01);
    serial_check("both", 32'b1110101011, 10, 5);
    xfer_end = 1'b1; suspend = 1'b1;
    step();
    xfer_end = 1'b0; suspend = 1'b0;
    check("both_susp0", suspended, 1'b0);
    check("both_ser0", ser_out, 1'b1);
    step();
    check("both_susp1", suspended, 1'b0);
    check("both_ser1", ser_out, 1'b0);
    step();
    check("both_susp2", suspended, 1'b0);
    check("both_ser2", ser_out, 1'b1);
    check("both_busy", busy, 1'b0);
    step();
    check("both_ser3", ser_out, 1'b0);

    // ---- asynchronous reset in the second id bit ----
    send_request(2'b11);
    repeat (4) step();
    check("mid_id_ser", ser_out, 1'b1);
    check("mid_id_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ser", ser_out, 1'b0);
    check("async_rst_ready", req_ready, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_request(2'b10);
    serial_check("fresh", 32'b111100, 6, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100us");
    $fatal(1, "watchdog");
  end

endmodule
